// File: rtl/ps2_rx_fifo_if.sv
// PS/2 receiver event stream.
// Head-of-FIFO data with valid/ready handshake.
interface ps2_rx_fifo_if;
  logic [10:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: sync, filter, frame decode,
// E0/F0 prefix folding and an event FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kbclk,
  input  logic             in,
  ps2_rx_fifo_if.master    m,
  output logic [CNT_W-1:0] fifo_level,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } st_t;

  logic [1:0]    kb_sy_q, dt_sy_q;
  logic          kb_f_q, kb_f_d;
  logic          dt_f_q, dt_f_d;
  logic [FW-1:0] kb_n_q, kb_n_d;
  logic [FW-1:0] dt_n_q, dt_n_d;
  logic          fall_q, fall_d;

  st_t           st_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    sh_q;
  logic          perr_q, serr_q;
  logic          byte_done_q;
  logic          frame_err_q;
  logic [TW-1:0] to_q;

  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          push;
  logic [10:0]   push_data;

  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] hd_q, hd_d;
  logic [AW-1:0] tl_q, tl_d;
  logic [CNT_W-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, wr;

  // Saturating filters: a level flips only after a full run of
  // FILTER_LEN consecutive samples that disagree with it.
  always_comb begin
    kb_f_d = kb_f_q;
    kb_n_d = '0;
    if (kb_sy_q[1] != kb_f_q) begin
      if (kb_n_q == FW'(FILTER_LEN - 1)) kb_f_d = ~kb_f_q;
      else kb_n_d = kb_n_q + FW'(1);
    end
    dt_f_d = dt_f_q;
    dt_n_d = '0;
    if (dt_sy_q[1] != dt_f_q) begin
      if (dt_n_q == FW'(FILTER_LEN - 1)) dt_f_d = ~dt_f_q;
      else dt_n_d = dt_n_q + FW'(1);
    end
    fall_d = kb_f_q & ~kb_f_d;
  end

  // Synchronisers and filter state; bus idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_sy_q <= 2'b11;
      dt_sy_q <= 2'b11;
      kb_f_q  <= 1'b1;
      dt_f_q  <= 1'b1;
      kb_n_q  <= '0;
      dt_n_q  <= '0;
      fall_q  <= 1'b0;
    end else begin
      kb_sy_q <= {kb_sy_q[0], kbclk};
      dt_sy_q <= {dt_sy_q[0], in};
      kb_f_q  <= kb_f_d;
      dt_f_q  <= dt_f_d;
      kb_n_q  <= kb_n_d;
      dt_n_q  <= dt_n_d;
      fall_q  <= fall_d;
    end
  end

  // Frame FSM with watchdog; advances only on filtered kbclk falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      to_q        <= '0;
    end else begin
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (st_q != IDLE && to_q == TW'(TIMEOUT_CYC - 1)) begin
        st_q        <= IDLE;
        frame_err_q <= 1'b1;
        to_q        <= '0;
      end else begin
        if (fall_q || st_q == IDLE) to_q <= '0;
        else to_q <= to_q + TW'(1);
        if (fall_q) begin
          unique case (st_q)
            IDLE: begin
              if (!dt_f_q) begin
                st_q      <= DATA;
                bit_cnt_q <= '0;
              end
            end
            DATA: begin
              sh_q      <= {dt_f_q, sh_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) st_q <= PARITY;
            end
            PARITY: begin
              perr_q <= ~(^{sh_q, dt_f_q});
              st_q   <= STOP;
            end
            STOP: begin
              serr_q      <= ~dt_f_q;
              byte_done_q <= 1'b1;
              st_q        <= IDLE;
            end
          endcase
        end
      end
    end
  end

  // Fold E0/F0 prefixes into the next event; bad frames flush them.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    push_data = '0;
    if (byte_done_q) begin
      unique case (1'b1)
        (perr_q | serr_q): begin
          push      = 1'b1;
          push_data = {1'b1, brk_q, ext_q, sh_q};
          ext_d     = 1'b0;
          brk_d     = 1'b0;
        end
        (sh_q == 8'hE0): ext_d = 1'b1;
        (sh_q == 8'hF0): brk_d = 1'b1;
        default: begin
          push      = 1'b1;
          push_data = {1'b0, brk_q, ext_q, sh_q};
          ext_d     = 1'b0;
          brk_d     = 1'b0;
        end
      endcase
    end
  end

  // FIFO pointer/level update; a full FIFO still accepts on a pop.
  always_comb begin
    pop   = (lvl_q != '0) & m.m_ready;
    full  = (lvl_q == CNT_W'(FIFO_DEPTH));
    wr    = push & (~full | pop);
    hd_d  = pop ? hd_q + AW'(1) : hd_q;
    tl_d  = wr ? tl_q + AW'(1) : tl_q;
    lvl_d = lvl_q;
    if (wr && !pop) lvl_d = lvl_q + CNT_W'(1);
    else if (pop && !wr) lvl_d = lvl_q - CNT_W'(1);
    ovf_d = ovf_q;
    if (push && !wr) ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Prefix flags, FIFO control state and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      hd_q  <= '0;
      tl_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
      hd_q  <= hd_d;
      tl_q  <= tl_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  // Event storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr) mem_q[tl_q] <= push_data;
  end

  assign m.m_valid  = (lvl_q != '0);
  assign m.m_data   = m.m_valid ? mem_q[hd_q] : '0;
  assign fifo_level = lvl_q;
  assign overflow   = ovf_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: decode, prefixes,
// error frames, timeout, overflow, glitches, reset.
module tb_ps2_rx_fifo;
  localparam int HALF = 20;
  localparam int TO   = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbclk = 1'b1;
  logic       dat = 1'b1;
  logic       ovf_clr = 1'b0;
  logic [2:0] level;
  logic       overflow;
  logic       frame_err;
  int         n_chk = 0;
  int         n_bad = 0;
  int         errs = 0;
  int         e0;

  ps2_rx_fifo_if bus ();

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN (4),
    .FIFO_DEPTH (4),
    .TIMEOUT_CYC(TO),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .kbclk     (kbclk),
    .in        (dat),
    .m         (bus),
    .fifo_level(level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .frame_err (frame_err)
  );

  always @(negedge clk) if (frame_err) errs++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic pbad,
                      input logic sbad, input int nb,
                      input int glitch_at);
    logic [10:0] f;
    f = {~sbad, (~^b) ^ pbad, b, 1'b0};
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_at) begin
        kbclk = 1'b0;
        tick(2);
        kbclk = 1'b1;
        tick(10);
      end
      dat = f[i];
      tick(HALF);
      kbclk = 1'b0;
      tick(HALF);
      kbclk = 1'b1;
    end
    tick(HALF);
    dat = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [10:0] exp);
    for (int i = 0; i < 100 && !bus.m_valid; i++) tick(1);
    chk({tag, "_vld"}, bus.m_valid, 1);
    chk(tag, bus.m_data, exp);
    bus.m_ready = 1'b1;
    tick(1);
    bus.m_ready = 1'b0;
  endtask

  initial begin
    bus.m_ready = 1'b0;
    tick(3);
    chk("rst_vld", bus.m_valid, 0);
    chk("rst_lvl", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b0;
    tick(5);

    send(8'h1C, 0, 0, 11, -1);
    chk("make_lvl", level, 1);
    pop_chk("make", 11'h01C);
    chk("make_empty", bus.m_valid, 0);

    send(8'hE0, 0, 0, 11, -1);
    send(8'hF0, 0, 0, 11, -1);
    chk("pfx_lvl", level, 0);
    send(8'h75, 0, 0, 11, -1);
    chk("ext_lvl", level, 1);
    pop_chk("ext_brk", 11'h375);
    send(8'h1C, 0, 0, 11, -1);
    pop_chk("pfx_clr", 11'h01C);

    send(8'h1C, 1, 0, 11, -1);
    pop_chk("perr", 11'h41C);
    send(8'h1C, 0, 1, 11, -1);
    pop_chk("serr", 11'h41C);
    send(8'h1C, 0, 0, 11, -1);
    pop_chk("after_err", 11'h01C);

    e0 = errs;
    send(8'h1C, 0, 0, 6, -1);
    tick(2 * TO);
    chk("to_pulse", errs - e0, 1);
    chk("to_lvl", level, 0);
    send(8'h1C, 0, 0, 11, -1);
    pop_chk("after_to", 11'h01C);

    send(8'h15, 0, 0, 11, -1);
    send(8'h16, 0, 0, 11, -1);
    send(8'h1C, 0, 0, 11, -1);
    send(8'h1D, 0, 0, 11, -1);
    send(8'h24, 0, 0, 11, -1);
    chk("full_lvl", level, 4);
    chk("ovf_set", overflow, 1);
    pop_chk("pop0", 11'h015);
    pop_chk("pop1", 11'h016);
    pop_chk("pop2", 11'h01C);
    pop_chk("pop3", 11'h01D);
    chk("drain_lvl", level, 0);
    chk("ovf_hold", overflow, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(1);
    chk("ovf_clr", overflow, 0);

    e0 = errs;
    dat = 1'b0;
    tick(10);
    kbclk = 1'b0;
    tick(2);
    kbclk = 1'b1;
    tick(10);
    dat = 1'b1;
    tick(TO + 50);
    chk("glitch_idle_ferr", errs - e0, 0);
    chk("glitch_idle_lvl", level, 0);
    send(8'h1C, 0, 0, 11, 4);
    chk("glitch_mid_lvl", level, 1);
    pop_chk("glitch_mid", 11'h01C);

    send(8'h1C, 0, 0, 5, -1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("midrst_lvl", level, 0);
    send(8'h1C, 0, 0, 11, -1);
    chk("midrst_one", level, 1);
    pop_chk("midrst", 11'h01C);
    chk("final_empty", bus.m_valid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=hang want=finish");
    $fatal(1, "watchdog");
  end
endmodule
